// File: rtl/salidas_pkg.sv
// Shared widths and output-operation codes for the UAZ output stage.
package salidas_pkg;

    localparam int unsigned W_DATO = 8;
    localparam int unsigned W_SEL  = 3;
    localparam int unsigned W_REG  = 3;

    localparam logic [W_SEL-1:0] SEL_NOP      = 3'b000;
    localparam logic [W_SEL-1:0] SEL_OUT_REG  = 3'b001;
    localparam logic [W_SEL-1:0] SEL_OUT_IND  = 3'b010;
    localparam logic [W_SEL-1:0] SEL_OUT_DATO = 3'b011;
    localparam logic [W_SEL-1:0] SEL_OUT_RY   = 3'b100;
    localparam logic [W_SEL-1:0] SEL_OUT_DIR  = 3'b101;
    localparam logic [W_SEL-1:0] SEL_CRUZ     = 3'b110;
    localparam logic [W_SEL-1:0] SEL_CLR      = 3'b111;

endpackage

// File: rtl/salidas_reg8.sv
// Bus-width register with asynchronous active-low clear and load enable.
module salidas_reg8
    import salidas_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [W_DATO-1:0] d_i,
    output logic [W_DATO-1:0] q_o
);

    logic [W_DATO-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/salidas.sv
// UAZ output stage: drives registered data and address buses from RX/RY per SELEC.
module salidas
    import salidas_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [W_SEL-1:0]  SELEC,
    input  logic [W_DATO-1:0] RX_DATO,
    input  logic [W_REG-1:0]  RY,
    input  logic [W_DATO-1:0] RY_DATO,
    output logic [W_DATO-1:0] DATO_OUT,
    output logic [W_DATO-1:0] DIR_OUT
);

    logic              dato_en_c;
    logic              dir_en_c;
    logic [W_DATO-1:0] dato_d;
    logic [W_DATO-1:0] dir_d;
    logic [W_DATO-1:0] ry_ext_c;

    assign ry_ext_c = W_DATO'(RY);

    // Opcode decode: load enables and next values; disabled register holds.
    always_comb begin
        dato_en_c = 1'b0;
        dir_en_c  = 1'b0;
        dato_d    = '0;
        dir_d     = '0;
        case (SELEC)
            SEL_OUT_REG: begin
                dato_en_c = 1'b1; dato_d = RX_DATO;
                dir_en_c  = 1'b1; dir_d  = ry_ext_c;
            end
            SEL_OUT_IND: begin
                dato_en_c = 1'b1; dato_d = RX_DATO;
                dir_en_c  = 1'b1; dir_d  = RY_DATO;
            end
            SEL_OUT_DATO: begin
                dato_en_c = 1'b1; dato_d = RX_DATO;
            end
            SEL_OUT_RY: begin
                dato_en_c = 1'b1; dato_d = RY_DATO;
                dir_en_c  = 1'b1; dir_d  = ry_ext_c;
            end
            SEL_OUT_DIR: begin
                dir_en_c  = 1'b1; dir_d  = RY_DATO;
            end
            SEL_CRUZ: begin
                dato_en_c = 1'b1; dato_d = RY_DATO;
                dir_en_c  = 1'b1; dir_d  = RX_DATO;
            end
            SEL_CLR: begin
                dato_en_c = 1'b1; dato_d = '0;
                dir_en_c  = 1'b1; dir_d  = '0;
            end
            default: begin
                dato_en_c = 1'b0;
                dir_en_c  = 1'b0;
            end
        endcase
    end

    salidas_reg8 u_dato_reg (
        .clk   (CLK),
        .rst_n (RST_N),
        .en_i  (dato_en_c),
        .d_i   (dato_d),
        .q_o   (DATO_OUT)
    );

    salidas_reg8 u_dir_reg (
        .clk   (CLK),
        .rst_n (RST_N),
        .en_i  (dir_en_c),
        .d_i   (dir_d),
        .q_o   (DIR_OUT)
    );

endmodule

// File: tb/tb_salidas.sv
// Directed-vector bench for the salidas output stage.
module tb_salidas;

    logic       CLK;
    logic       RST_N;
    logic [2:0] SELEC;
    logic [7:0] RX_DATO;
    logic [2:0] RY;
    logic [7:0] RY_DATO;
    logic [7:0] DATO_OUT;
    logic [7:0] DIR_OUT;

    int n_assert = 0;
    int n_fail   = 0;

    salidas dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .SELEC    (SELEC),
        .RX_DATO  (RX_DATO),
        .RY       (RY),
        .RY_DATO  (RY_DATO),
        .DATO_OUT (DATO_OUT),
        .DIR_OUT  (DIR_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] rx,
                         input logic [2:0] ry_i, input logic [7:0] ryd);
        SELEC   = sel;
        RX_DATO = rx;
        RY      = ry_i;
        RY_DATO = ryd;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset asserted with an active opcode: reset wins, even across edges
        RST_N = 1'b0;
        drive(3'b010, 8'hAA, 3'd5, 8'hBB);
        #3;
        check("rst_async_dato", DATO_OUT, 8'h00);
        check("rst_async_dir",  DIR_OUT,  8'h00);
        tick();
        tick();
        check("rst_held_dato", DATO_OUT, 8'h00);
        check("rst_held_dir",  DIR_OUT,  8'h00);

        RST_N = 1'b1;
        drive(3'b000, 8'h11, 3'd7, 8'h22);
        tick();
        check("nop1_dato", DATO_OUT, 8'h00);
        check("nop1_dir",  DIR_OUT,  8'h00);
        tick();
        check("nop2_dato", DATO_OUT, 8'h00);
        check("nop2_dir",  DIR_OUT,  8'h00);

        drive(3'b011, 8'h55, 3'd6, 8'h33);
        tick();
        check("out_dato_dato", DATO_OUT, 8'h55);
        check("out_dato_dir",  DIR_OUT,  8'h00);

        drive(3'b101, 8'h92, 3'd2, 8'hE3);
        tick();
        check("out_dir_dato", DATO_OUT, 8'h55);
        check("out_dir_dir",  DIR_OUT,  8'hE3);

        drive(3'b110, 8'hCC, 3'd1, 8'h1C);
        tick();
        check("cruz_dato", DATO_OUT, 8'h1C);
        check("cruz_dir",  DIR_OUT,  8'hCC);

        drive(3'b001, 8'h55, 3'd6, 8'h1C);
        tick();
        check("out_reg_dato", DATO_OUT, 8'h55);
        check("out_reg_dir",  DIR_OUT,  8'h06);

        drive(3'b100, 8'h55, 3'd3, 8'hA7);
        tick();
        check("out_ry_dato", DATO_OUT, 8'hA7);
        check("out_ry_dir",  DIR_OUT,  8'h03);

        drive(3'b111, 8'h5A, 3'd7, 8'hA5);
        tick();
        check("clr_dato", DATO_OUT, 8'h00);
        check("clr_dir",  DIR_OUT,  8'h00);

        drive(3'b010, 8'hF0, 3'd4, 8'h0F);
        tick();
        check("out_ind_dato", DATO_OUT, 8'hF0);
        check("out_ind_dir",  DIR_OUT,  8'h0F);

        // NOP with new inputs must hold both buses
        drive(3'b000, 8'h12, 3'd7, 8'h34);
        tick();
        check("nop_hold_dato", DATO_OUT, 8'hF0);
        check("nop_hold_dir",  DIR_OUT,  8'h0F);

        // RY=7 zero-extended onto the address bus
        drive(3'b001, 8'h81, 3'd7, 8'hFF);
        tick();
        check("ry7_dato", DATO_OUT, 8'h81);
        check("ry7_dir",  DIR_OUT,  8'h07);

        drive(3'b010, 8'hF0, 3'd4, 8'h0F);
        tick();
        check("ind2_dato", DATO_OUT, 8'hF0);
        check("ind2_dir",  DIR_OUT,  8'h0F);

        // Mid-cycle reset clears without an edge
        #1;
        RST_N = 1'b0;
        #1;
        check("midrst_dato", DATO_OUT, 8'h00);
        check("midrst_dir",  DIR_OUT,  8'h00);
        #1;
        RST_N = 1'b1;
        #1;
        check("release_noedge_dato", DATO_OUT, 8'h00);
        check("release_noedge_dir",  DIR_OUT,  8'h00);
        tick();
        check("post_rst_dato", DATO_OUT, 8'hF0);
        check("post_rst_dir",  DIR_OUT,  8'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
